// File: rtl/vga_frame_buffer.sv
// Double-buffered pixel store: (x,y) writes into the back bank, raster reads from the front bank, 1-cycle read latency.
// wr_ready drops while a swap is pending; banks swap only on rd_frame_start, so the display never sees a half-drawn frame.
module vga_frame_buffer #(
    parameter int PIXEL_W = 3,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int X_W     = 10,
    parameter int Y_W     = 9,
    parameter int ADDR_W  = 19
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [X_W-1:0]     wr_x,
    input  logic [Y_W-1:0]     wr_y,
    input  logic [PIXEL_W-1:0] wr_pixel,
    output logic               wr_oob,
    input  logic               swap_req,
    output logic               swap_pending,
    output logic               front_bank,
    input  logic               rd_frame_start,
    input  logic               rd_en,
    output logic [PIXEL_W-1:0] rd_pixel,
    output logic               rd_valid
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIXEL_W-1:0] bank0_mem [DEPTH];
    logic [PIXEL_W-1:0] bank1_mem [DEPTH];

    logic               front_bank_q, front_bank_d;
    logic               swap_pending_q, swap_pending_d;
    logic               wr_oob_q, wr_oob_d;
    logic [ADDR_W-1:0]  scan_q, scan_d;
    logic               rd_valid_q, rd_valid_d;
    logic [PIXEL_W-1:0] rd_pixel_q, rd_pixel_d;

    logic               wr_fire;
    logic               wr_in_range;
    logic               frame_take;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    assign wr_ready = !reset && !swap_pending_q;

    always_comb begin
        wr_in_range    = (int'(wr_x) < H_RES) && (int'(wr_y) < V_RES);
        wr_addr        = ADDR_W'(wr_y) * ADDR_W'(H_RES) + ADDR_W'(wr_x);
        wr_fire        = wr_valid && wr_ready;
        wr_oob_d       = wr_oob_q | (wr_fire & !wr_in_range);

        // A swap_req coinciding with the frame start it cannot use waits for the next one.
        frame_take     = rd_frame_start && swap_pending_q;
        front_bank_d   = front_bank_q ^ frame_take;
        swap_pending_d = frame_take ? 1'b0 : (swap_pending_q | swap_req);

        rd_addr        = rd_frame_start ? '0 : scan_q;
        scan_d         = rd_frame_start ? '0 : scan_q;
        rd_valid_d     = rd_en;
        rd_pixel_d     = rd_pixel_q;
        if (rd_en) begin
            scan_d     = (rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr + 1'b1;
            rd_pixel_d = front_bank_d ? bank1_mem[rd_addr[IDX_W-1:0]]
                                      : bank0_mem[rd_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk_50) begin
        if (reset) begin
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            wr_oob_q       <= 1'b0;
            scan_q         <= '0;
            rd_valid_q     <= 1'b0;
            rd_pixel_q     <= '0;
        end else begin
            front_bank_q   <= front_bank_d;
            swap_pending_q <= swap_pending_d;
            wr_oob_q       <= wr_oob_d;
            scan_q         <= scan_d;
            rd_valid_q     <= rd_valid_d;
            rd_pixel_q     <= rd_pixel_d;
        end
    end

    // Writes never hit the front bank: wr_ready is low whenever a swap could happen.
    always_ff @(posedge clk_50) begin
        if (wr_fire && wr_in_range) begin
            if (front_bank_q) begin
                bank0_mem[wr_addr[IDX_W-1:0]] <= wr_pixel;
            end else begin
                bank1_mem[wr_addr[IDX_W-1:0]] <= wr_pixel;
            end
        end
    end

    assign wr_oob       = wr_oob_q;
    assign swap_pending = swap_pending_q;
    assign front_bank   = front_bank_q;
    assign rd_valid     = rd_valid_q;
    assign rd_pixel     = rd_pixel_q;
endmodule

// File: tb/tb_vga_frame_buffer.sv
// Bench for vga_frame_buffer at 4x3 resolution: directed sequences, a cycle table and a randomized run against a frame model.
module tb_vga_frame_buffer;
    localparam int PW = 3;
    localparam int HR = 4;
    localparam int VR = 3;
    localparam int NPIX = HR * VR;

    logic          clk_50 = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [2:0]    wr_x;
    logic [1:0]    wr_y;
    logic [PW-1:0] wr_pixel;
    logic          wr_oob;
    logic          swap_req;
    logic          swap_pending;
    logic          front_bank;
    logic          rd_frame_start;
    logic          rd_en;
    logic [PW-1:0] rd_pixel;
    logic          rd_valid;

    vga_frame_buffer #(
        .PIXEL_W(PW), .H_RES(HR), .V_RES(VR), .X_W(3), .Y_W(2), .ADDR_W(4)
    ) dut (
        .clk_50(clk_50), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_pixel(wr_pixel), .wr_oob(wr_oob),
        .swap_req(swap_req), .swap_pending(swap_pending), .front_bank(front_bank),
        .rd_frame_start(rd_frame_start), .rd_en(rd_en),
        .rd_pixel(rd_pixel), .rd_valid(rd_valid)
    );

    always #5 clk_50 = ~clk_50;

    int n_cmp = 0;
    int n_fail = 0;

    // Frame model: two pixel arrays plus which entries hold a known value.
    int m_mem   [2][NPIX];
    bit m_known [2][NPIX];
    int m_front, m_pend, m_oob, m_scan, m_rvalid, m_rpix;
    bit m_rpix_known;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int bank, a, nf, take;
        if (reset) begin
            m_front = 0; m_pend = 0; m_oob = 0; m_scan = 0;
            m_rvalid = 0; m_rpix = 0; m_rpix_known = 1'b1;
        end else begin
            if (wr_valid && m_pend == 0) begin
                if (int'(wr_x) < HR && int'(wr_y) < VR) begin
                    bank = 1 - m_front;
                    a = int'(wr_y) * HR + int'(wr_x);
                    m_mem[bank][a] = int'(wr_pixel);
                    m_known[bank][a] = 1'b1;
                end else begin
                    m_oob = 1;
                end
            end
            take = (rd_frame_start && m_pend == 1) ? 1 : 0;
            nf = take ? 1 - m_front : m_front;
            m_pend = take ? 0 : ((m_pend == 1 || swap_req) ? 1 : 0);
            if (rd_frame_start) m_scan = 0;
            if (rd_en) begin
                m_rpix = m_mem[nf][m_scan];
                m_rpix_known = m_known[nf][m_scan];
                m_scan = (m_scan + 1) % NPIX;
                m_rvalid = 1;
            end else begin
                m_rvalid = 0;
            end
            m_front = nf;
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        model_edge();
        #1;
        check("wr_ready", int'(wr_ready), (!reset && m_pend == 0) ? 1 : 0);
        check("front_bank", int'(front_bank), m_front);
        check("swap_pending", int'(swap_pending), m_pend);
        check("wr_oob", int'(wr_oob), m_oob);
        check("rd_valid", int'(rd_valid), m_rvalid);
        if (m_rpix_known) check("rd_pixel", int'(rd_pixel), m_rpix);
    endtask

    task automatic write_px(input int x, input int y, input int p);
        wr_valid = 1'b1; wr_x = 3'(x); wr_y = 2'(y); wr_pixel = 3'(p);
        step();
        wr_valid = 1'b0;
    endtask

    typedef struct {
        bit rst; bit wv; int x; int y; int p; bit sw; bit fs; bit ren;
        int e_front; int e_pend; int e_oob;
    } vec_t;

    vec_t tbl [16];

    initial begin
        tbl[0]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 7, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 7, 0, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 7, 0, 1, 0, 1, 0, 0};
        tbl[7]  = '{0, 1, 0, 0, 7, 0, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 1, 4, 0, 3, 0, 0, 0, 1, 0, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1};
        tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NPIX; a++) begin
                m_mem[b][a] = 0; m_known[b][a] = 1'b0;
            end
        m_front = 0; m_pend = 0; m_oob = 0; m_scan = 0;
        m_rvalid = 0; m_rpix = 0; m_rpix_known = 1'b0;

        reset = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_pixel = '0;
        swap_req = 1'b0; rd_frame_start = 1'b0; rd_en = 1'b0;

        // Reset held for three cycles, then released.
        repeat (3) step();
        check("rst_wr_ready", int'(wr_ready), 0);
        check("rst_rd_pixel", int'(rd_pixel), 0);
        reset = 1'b0;
        #1;
        check("ready_after_release", int'(wr_ready), 1);

        // Fill bank 1 (pixel 5 at x=1,y=2), swap it to front, fill bank 0, read 10 beats.
        for (int a = 0; a < NPIX; a++)
            write_px(a % HR, a / HR, (a == 9) ? 5 : (a * 3 + 1) % 8);
        swap_req = 1'b1; step(); swap_req = 1'b0;
        check("t2_pending", int'(swap_pending), 1);
        rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
        check("t2_front", int'(front_bank), 1);
        for (int a = 0; a < NPIX; a++)
            write_px(a % HR, a / HR, (a + 2) % 8);
        rd_en = 1'b1;
        repeat (10) step();
        check("t2_beat10_valid", int'(rd_valid), 1);
        check("t2_beat10_pixel", int'(rd_pixel), 5);
        rd_en = 1'b0;
        step();

        // Cycle table: same-cycle swap, write stall, out-of-range write, reset with swap pending.
        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; wr_valid = tbl[i].wv;
            wr_x = 3'(tbl[i].x); wr_y = 2'(tbl[i].y); wr_pixel = 3'(tbl[i].p);
            swap_req = tbl[i].sw; rd_frame_start = tbl[i].fs; rd_en = tbl[i].ren;
            step();
            check($sformatf("tbl%0d_front", i), int'(front_bank), tbl[i].e_front);
            check($sformatf("tbl%0d_pend", i), int'(swap_pending), tbl[i].e_pend);
            check($sformatf("tbl%0d_oob", i), int'(wr_oob), tbl[i].e_oob);
        end
        reset = 1'b0; wr_valid = 1'b0; swap_req = 1'b0; rd_frame_start = 1'b0; rd_en = 1'b0;

        // Bank 0 is front again: 13 reads wrap to address 0, then restart mid-scan.
        rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
        rd_en = 1'b1;
        for (int beat = 1; beat <= 13; beat++) begin
            step();
            if (beat == 1 || beat == 13) check($sformatf("wrap_beat%0d", beat), int'(rd_pixel), 7);
        end
        repeat (4) step();
        rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
        check("restart_addr0", int'(rd_pixel), 7);
        step();
        check("restart_addr1", int'(rd_pixel), 3);
        rd_en = 1'b0;

        // Raster readback of bank 1 through the model.
        swap_req = 1'b1; step(); swap_req = 1'b0;
        rd_frame_start = 1'b1; step(); rd_frame_start = 1'b0;
        check("readback_front", int'(front_bank), 1);
        rd_en = 1'b1; repeat (NPIX) step(); rd_en = 1'b0;
        step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom % 64) == 0;
            wr_valid       = $urandom % 2;
            wr_x           = 3'($urandom % 8);
            wr_y           = 2'($urandom % 4);
            wr_pixel       = 3'($urandom % 8);
            swap_req       = ($urandom % 8) == 0;
            rd_frame_start = ($urandom % 16) == 0;
            rd_en          = ($urandom % 4) != 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_frame_buffer.md
# vga_frame_buffer

Parametrised, double-buffered pixel store between the drawing logic and the VGA timing/output stage. The drawing side writes pixels by (x, y) coordinate into the back bank through a valid/ready handshake. The display side streams pixels out of the front bank in raster order, with one-cycle registered latency. Banks swap only at a frame boundary, so the display never shows a partially drawn frame.

## Interface
Parameters:
- PIXEL_W, 3: bits per pixel.
- H_RES, 640: pixels per line.
- V_RES, 480: lines per frame.
- X_W, 10: width of x coordinate; 2^X_W >= H_RES.
- Y_W, 9: width of y coordinate; 2^Y_W >= V_RES.
- ADDR_W, 19: width of the in-bank pixel address; 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_x  in  X_W  write column.
- wr_y  in  Y_W  write row.
- wr_pixel  in  PIXEL_W  write data.
- wr_oob  out  1  sticky flag: an out-of-range write was dropped.
- swap_req  in  1  one-cycle pulse: the back bank is complete.
- swap_pending  out  1  swap requested, not yet taken.
- front_bank  out  1  bank currently displayed.
- rd_frame_start  in  1  one-cycle pulse from VGA timing at the start of each frame.
- rd_en  in  1  fetch the next raster pixel.
- rd_pixel  out  PIXEL_W  fetched pixel.
- rd_valid  out  1  rd_pixel is valid this cycle.

## Operation
- **Storage.** 2 banks of H_RES*V_RES entries of PIXEL_W bits each. Memory contents are not initialised and are not cleared by reset.
- **Write.**
  - A transfer happens when wr_valid && wr_ready.
  - Target address = wr_y*H_RES + wr_x in bank !front_bank.
  - wr_ready = !reset && !swap_pending. It is derived from registered state only and never depends on wr_valid.
- **Out-of-range write.** If wr_x >= H_RES or wr_y >= V_RES, the transfer still completes, memory is unchanged, and wr_oob is set. wr_oob is cleared only by reset.
- **Swap request.**
  - swap_req sets swap_pending on the next edge.
  - A second swap_req while pending has no effect.
- **Frame start.** On rd_frame_start:
  - the scan counter loads 0;
  - if swap_pending was already 1 before this cycle, front_bank toggles and swap_pending clears;
  - swap_req arriving in the same cycle as rd_frame_start is deferred: it sets swap_pending and is taken at the following rd_frame_start.
- **Read.**
  - On rd_en, the block reads the front bank at the scan address.
  - The scan counter increments and wraps from H_RES*V_RES-1 to 0.
  - If rd_en and rd_frame_start occur in the same cycle, the read uses address 0 and the new front_bank (after any swap taken that cycle); the counter becomes 1.
- **Same-cycle write and read.** The two ports always target different banks, so there is no read/write collision.

## Timing
- Reset values:
  - wr_ready = 0 while reset is high, 1 in the first cycle after reset deasserts;
  - wr_oob = 0, swap_pending = 0, front_bank = 0;
  - rd_valid = 0, rd_pixel = 0, scan counter = 0.
- Read latency: rd_en at edge N gives rd_pixel/rd_valid from edge N+1, for exactly one cycle per rd_en. Back-to-back rd_en gives one pixel per cycle.
- rd_pixel holds its last value when rd_valid = 0.
- Write latency: a write accepted at edge N is visible to reads issued from edge N+1 onward, once that bank becomes front.
- Swap: swap_req at edge N gives swap_pending = 1 from N+1. front_bank toggles at the first rd_frame_start edge after N.
- Reset mid-operation: a pending swap is discarded, the scan restarts at 0, and an in-flight read is dropped (rd_valid = 0 in the next cycle).

## Test plan
Directed tests use H_RES=4, V_RES=3, PIXEL_W=3.
1. **Reset.** Hold reset 3 cycles -> every output at its reset value; wr_ready = 1 in the first cycle after release.
2. **Write, swap, read.**
   - Stimulus: write (x=1, y=2, pixel=5) to bank 1; pulse swap_req; pulse rd_frame_start; issue rd_en for 10 cycles.
   - Required: front_bank = 1; the 10th rd_valid beat (address 9) shows rd_pixel = 5.
3. **Write stall.**
   - Stimulus: swap_req; hold wr_valid with (0, 0, 7).
   - Required: wr_ready = 0 until the cycle after rd_frame_start; the write then lands in the new back bank, bank 0.
4. **Out-of-range write.**
   - Stimulus: write x=4, y=0, pixel=3.
   - Required: handshake completes; wr_oob = 1 and stays 1; a raster readback of both banks shows no change.
5. **Wrap and restart.**
   - Stimulus: 13 consecutive rd_en.
   - Required: beats 1 and 13 both read address 0.
   - Stimulus: assert rd_frame_start with rd_en mid-scan.
   - Required: the next beat is address 0, then address 1.
6. **Same-cycle and reset cases.**
   - Stimulus: swap_req in the same cycle as rd_frame_start.
   - Required: front_bank unchanged at that edge; it toggles at the next rd_frame_start.
   - Stimulus: reset while swap_pending = 1.
   - Required: swap_pending = 0, front_bank = 0.
